// File: rtl/anita4_l2_trigger_receiver.sv
// -----------------------------------------------------------------------------
// anita4_l2_trigger_receiver
//
// Receive end of the SURF L2 trigger lines. Every line is an asynchronous
// oneshot. It is synchronised, edge-detected and then opens a short
// coincidence window. When two adjacent lines (k, k+1) are open together and
// one of them has just produced an edge, a single-cycle L3 pulse is issued.
// A holdoff period follows, during which further coincidences are ignored.
// Gated per-line rate scalers count edges and publish their totals once per
// gate period.
//
// Ports
//   clk_i          in   1                        trigger clock (250 MHz)
//   rst_i          in   1                        asynchronous reset, active-high
//   trig_i         in   NUM_LINES                L2 lines, asynchronous to clk_i
//   mask_i         in   NUM_LINES                1 = line ignored (no window, no count)
//   l3_o           out  1                        one-cycle L3 trigger pulse
//   l3_pair_o      out  NUM_LINES-1              bit k = pair (k,k+1) fired, held to next l3_o
//   scaler_o       out  NUM_LINES*SCALER_WIDTH   latched counts, line k at [k*W +: W]
//   scaler_valid_o out  1                        one-cycle pulse when scaler_o updates
// -----------------------------------------------------------------------------
module anita4_l2_trigger_receiver #(
   parameter int NUM_LINES    = 4,
   parameter int WINDOW       = 3,
   parameter int HOLDOFF      = 8,
   parameter int SCALER_WIDTH = 16,
   parameter int GATE_CYCLES  = 250000
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NUM_LINES-1:0]              trig_i,
   input  logic [NUM_LINES-1:0]              mask_i,
   output logic                              l3_o,
   output logic [NUM_LINES-2:0]              l3_pair_o,
   output logic [NUM_LINES*SCALER_WIDTH-1:0] scaler_o,
   output logic                              scaler_valid_o
);

   localparam int WCW = $clog2(WINDOW + 1);
   localparam int HCW = $clog2(HOLDOFF + 1);
   localparam int GCW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

   localparam logic [WCW-1:0]          WINDOW_LOAD  = WCW'(WINDOW);
   localparam logic [HCW-1:0]          HOLDOFF_LOAD = HCW'(HOLDOFF);
   localparam logic [GCW-1:0]          GATE_LAST    = GCW'(GATE_CYCLES - 1);
   localparam logic [SCALER_WIDTH-1:0] CNT_MAX      = '1;

   typedef enum logic {
      ST_IDLE,
      ST_HOLD
   } state_t;

   // ---------------------------------------------------------------------------
   // Synchroniser and edge detect. s0 may go metastable and feeds nothing but
   // s1; s1d is s1 one cycle later, so a held-high line yields a single edge.
   // ---------------------------------------------------------------------------
   logic [NUM_LINES-1:0] s0;
   logic [NUM_LINES-1:0] s1;
   logic [NUM_LINES-1:0] s1d;
   logic [NUM_LINES-1:0] rise;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s0  <= '0;
         s1  <= '0;
         s1d <= '0;
      end else begin
         // NOTE: non-blocking assignments make every stage sample the value the
         // previous stage held before this edge, so the chain shifts by one.
         s0  <= trig_i;
         s1  <= s0;
         s1d <= s1;
      end
   end

   // The mask acts on the edge, so it stops new windows and counts but leaves
   // a window that is already running untouched.
   assign rise = s1 & ~s1d & ~mask_i;

   // ---------------------------------------------------------------------------
   // Coincidence windows: a line is open in its edge cycle and for WINDOW
   // cycles after it. A new edge reloads the counter.
   // ---------------------------------------------------------------------------
   logic [WCW-1:0]       wcnt [NUM_LINES];
   logic [NUM_LINES-1:0] open_v;
   logic [NUM_LINES-2:0] hit_v;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: the window counters are cleared on reset because a stale
         // count would open a window and fake a coincidence after release.
         for (int k = 0; k < NUM_LINES; k++) wcnt[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_LINES; k++) begin
            if (rise[k])
               wcnt[k] <= WINDOW_LOAD;
            else if (wcnt[k] != '0)
               wcnt[k] <= wcnt[k] - WCW'(1);
         end
      end
   end

   always_comb begin
      open_v = '0;
      for (int k = 0; k < NUM_LINES; k++)
         open_v[k] = rise[k] | (wcnt[k] != '0);
   end

   // A hit needs an edge on one of the two lines, so a coincidence is taken
   // only on its later edge and is never counted twice.
   always_comb begin
      hit_v = '0;
      for (int k = 0; k < NUM_LINES - 1; k++)
         hit_v[k] = open_v[k] & open_v[k+1] & (rise[k] | rise[k+1]);
   end

   // ---------------------------------------------------------------------------
   // L3 issue / holdoff FSM. l3_o is registered, so it rises the cycle after
   // the hit. HOLD lasts HOLDOFF cycles, making the earliest next l3_o
   // HOLDOFF+1 cycles after the previous one.
   // ---------------------------------------------------------------------------
   state_t               state_q;
   state_t               state_d;
   logic [HCW-1:0]       hcnt_q;
   logic [HCW-1:0]       hcnt_d;
   logic                 l3_d;
   logic [NUM_LINES-2:0] pair_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         hcnt_q    <= '0;
         l3_o      <= 1'b0;
         l3_pair_o <= '0;
      end else begin
         state_q   <= state_d;
         hcnt_q    <= hcnt_d;
         l3_o      <= l3_d;
         l3_pair_o <= pair_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets its default before the case statement, so no
      // path leaves one unassigned and no latch is inferred.
      state_d = state_q;
      hcnt_d  = hcnt_q;
      l3_d    = 1'b0;
      pair_d  = l3_pair_o;
      case (state_q)
         ST_IDLE: begin
            if (|hit_v) begin
               l3_d    = 1'b1;
               pair_d  = hit_v;
               hcnt_d  = HOLDOFF_LOAD;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            hcnt_d = hcnt_q - HCW'(1);
            if (hcnt_q == HCW'(1))
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Gated rate scalers. On the gate's terminal cycle the running counts are
   // published and restarted; an edge in that same cycle seeds the new gate.
   // ---------------------------------------------------------------------------
   logic [GCW-1:0]          gate_cnt;
   logic                    gate_tc;
   logic [SCALER_WIDTH-1:0] cnt [NUM_LINES];

   assign gate_tc = (gate_cnt == GATE_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         gate_cnt <= '0;
      else if (gate_tc)
         gate_cnt <= '0;
      else
         gate_cnt <= gate_cnt + GCW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NUM_LINES; k++) cnt[k] <= '0;
         scaler_o       <= '0;
         scaler_valid_o <= 1'b0;
      end else begin
         scaler_valid_o <= gate_tc;
         for (int k = 0; k < NUM_LINES; k++) begin
            if (gate_tc) begin
               scaler_o[k*SCALER_WIDTH +: SCALER_WIDTH] <= cnt[k];
               cnt[k] <= rise[k] ? SCALER_WIDTH'(1) : '0;
            end else if (rise[k] && (cnt[k] != CNT_MAX)) begin
               cnt[k] <= cnt[k] + SCALER_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_anita4_l2_trigger_receiver.sv
// -----------------------------------------------------------------------------
// tb_anita4_l2_trigger_receiver
//
// Directed bench for anita4_l2_trigger_receiver with WINDOW=3, HOLDOFF=8,
// GATE_CYCLES=100 and SCALER_WIDTH=4 (narrow so saturation is reachable in a
// single gate). Inputs change 1 time unit after a rising edge; outputs are
// read at that same point, well away from the active edge.
//
// Stimulus timing: trig_i set in cycle k is captured by s0 at the next edge,
// reaches s1 one edge later, so the edge is seen in cycle k+2 and a resulting
// l3_o is high in cycle k+3.
// -----------------------------------------------------------------------------
module tb_anita4_l2_trigger_receiver;

   localparam int NUM_LINES    = 4;
   localparam int WINDOW       = 3;
   localparam int HOLDOFF      = 8;
   localparam int SCALER_WIDTH = 4;
   localparam int GATE_CYCLES  = 100;
   localparam int SW           = SCALER_WIDTH;

   logic                              clk_i = 1'b0;
   logic                              rst_i = 1'b1;
   logic [NUM_LINES-1:0]              trig_i = '0;
   logic [NUM_LINES-1:0]              mask_i = '0;
   logic                              l3_o;
   logic [NUM_LINES-2:0]              l3_pair_o;
   logic [NUM_LINES*SCALER_WIDTH-1:0] scaler_o;
   logic                              scaler_valid_o;

   int n_checks = 0;
   int n_pass   = 0;
   int l3_cnt   = 0;
   int base;
   int waited;
   int n_after_rst;
   logic [3:0] v4;

   anita4_l2_trigger_receiver #(
      .NUM_LINES   (NUM_LINES),
      .WINDOW      (WINDOW),
      .HOLDOFF     (HOLDOFF),
      .SCALER_WIDTH(SCALER_WIDTH),
      .GATE_CYCLES (GATE_CYCLES)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .trig_i        (trig_i),
      .mask_i        (mask_i),
      .l3_o          (l3_o),
      .l3_pair_o     (l3_pair_o),
      .scaler_o      (scaler_o),
      .scaler_valid_o(scaler_valid_o)
   );

   always #5 clk_i = ~clk_i;

   // Counts l3_o pulses, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (l3_o) l3_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
   endtask

   // Drive trig_i for one cycle and advance to just after the next edge.
   task automatic step(input logic [3:0] v);
      trig_i = v;
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(4'b0000);
   endtask

   // Advance until scaler_valid_o is seen, at most 'limit' cycles.
   task automatic wait_valid(input int limit, output int n);
      n = 0;
      while (n < limit) begin
         @(posedge clk_i);
         #1;
         n++;
         if (scaler_valid_o) break;
      end
   endtask

   function automatic logic [SW-1:0] sc(input int k);
      return scaler_o[k*SW +: SW];
   endfunction

   // Pair (0,1) hits first; pair (2,3) hits 'gap' cycles later.
   task automatic holdoff_probe(input int gap, input int exp_pulses, input logic [2:0] exp_pair);
      base = l3_cnt;
      step(4'b0011);
      repeat (gap - 1) step(4'b0011);
      step(4'b1111);
      step(4'b1111);
      step(4'b1111);
      check($sformatf("hold_gap%0d_l3", gap), l3_o, (exp_pulses == 2) ? 1 : 0);
      check($sformatf("hold_gap%0d_pair", gap), l3_pair_o, exp_pair);
      idle(20);
      check($sformatf("hold_gap%0d_pulses", gap), l3_cnt - base, exp_pulses);
   endtask

   initial begin
      // ---- reset state ----
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_l3", l3_o, 0);
      check("rst_pair", l3_pair_o, 0);
      check("rst_scaler", scaler_o, 0);
      check("rst_valid", scaler_valid_o, 0);
      rst_i = 1'b0;
      idle(5);

      // ---- 1a: line1 edge 3 cycles after line0 -> pair 0 fires ----
      base = l3_cnt;
      step(4'b0001);
      step(4'b0001);
      step(4'b0001);
      step(4'b0011);
      step(4'b0011);
      step(4'b0011);
      check("win3_l3", l3_o, 1);
      check("win3_pair", l3_pair_o, 3'b001);
      idle(20);
      check("win3_pulses", l3_cnt - base, 1);

      // ---- 1b: gap of 4 cycles -> window closed, no l3 ----
      base = l3_cnt;
      repeat (4) step(4'b0001);
      repeat (4) step(4'b0011);
      idle(20);
      check("win4_pulses", l3_cnt - base, 0);
      check("win4_pair_held", l3_pair_o, 3'b001);

      // ---- 1c: masking line1 after its edge keeps its window open ----
      base = l3_cnt;
      step(4'b0010);
      step(4'b0010);
      step(4'b0010);
      mask_i = 4'b0010;
      step(4'b0110);
      step(4'b0110);
      step(4'b0110);
      check("maskwin_l3", l3_o, 1);
      check("maskwin_pair", l3_pair_o, 3'b010);
      idle(20);
      mask_i = 4'b0000;
      check("maskwin_pulses", l3_cnt - base, 1);

      // ---- 2a: lines 0,1,2 rise together -> two pairs, one l3 ----
      base = l3_cnt;
      step(4'b0111);
      step(4'b0111);
      step(4'b0111);
      check("multi_l3", l3_o, 1);
      check("multi_pair", l3_pair_o, 3'b011);
      idle(20);
      check("multi_pulses", l3_cnt - base, 1);

      // ---- 2b: lines 1,2 together, line0 one cycle later. Pair 1 fires on
      // the first cycle; the pair-0 hit a cycle later lands in holdoff. ----
      base = l3_cnt;
      step(4'b0110);
      step(4'b0111);
      step(4'b0111);
      check("late_l3", l3_o, 1);
      check("late_pair", l3_pair_o, 3'b010);
      idle(20);
      check("late_pulses", l3_cnt - base, 1);
      check("late_pair_held", l3_pair_o, 3'b010);

      // ---- 3: holdoff. Second hit 4 and 8 cycles later is dropped; 9 later
      // is the earliest accepted (l3_o HOLDOFF+1 cycles after the first). ----
      holdoff_probe(4, 1, 3'b001);
      holdoff_probe(8, 1, 3'b001);
      holdoff_probe(9, 2, 3'b100);

      // ---- 4: scalers, line2 masked ----
      mask_i = 4'b0100;
      wait_valid(250, waited);
      check("gate_sync_valid", scaler_valid_o, 1);
      for (int p = 0; p < 5; p++) begin
         v4 = 4'b0001;
         if (p < 2) v4[3] = 1'b1;
         if (p < 3) v4[2] = 1'b1;
         repeat (3) step(v4);
         repeat (3) step(4'b0000);
      end
      wait_valid(150, waited);
      check("gate_valid", scaler_valid_o, 1);
      check("gate_len", waited, GATE_CYCLES - 30);
      check("scaler_line0", sc(0), 5);
      check("scaler_line1", sc(1), 0);
      check("scaler_line2_masked", sc(2), 0);
      check("scaler_line3", sc(3), 2);
      mask_i = 4'b0000;

      // Edge on line0 in the gate's last cycle belongs to the next gate.
      repeat (GATE_CYCLES - 3) step(4'b0000);
      step(4'b0001);
      wait_valid(150, waited);
      check("tc_edge_valid", scaler_valid_o, 1);
      check("tc_edge_old_gate", sc(0), 0);
      trig_i = 4'b0000;
      wait_valid(150, waited);
      check("tc_edge_valid2", scaler_valid_o, 1);
      check("tc_edge_new_gate", sc(0), 1);

      // ---- 5: 20 edges on line1 saturate a 4-bit scaler at 15 ----
      for (int p = 0; p < 20; p++) begin
         repeat (3) step(4'b0010);
         step(4'b0000);
      end
      wait_valid(150, waited);
      check("sat_valid", scaler_valid_o, 1);
      check("sat_gate_len", waited, GATE_CYCLES - 80);
      check("sat_line1", sc(1), 15);
      check("sat_line0", sc(0), 0);

      // ---- 6: reset during HOLD with windows open ----
      step(4'b0011);
      step(4'b0011);
      step(4'b0011);
      check("prerst_l3", l3_o, 1);
      trig_i = 4'b0000;
      rst_i  = 1'b1;
      #1;
      check("midrst_l3", l3_o, 0);
      check("midrst_pair", l3_pair_o, 0);
      check("midrst_scaler", scaler_o, 0);
      check("midrst_valid", scaler_valid_o, 0);
      check("midrst_wcnt0", dut.wcnt[0], 0);
      check("midrst_wcnt1", dut.wcnt[1], 0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      n_after_rst = 0;
      step(4'b0011);
      step(4'b0011);
      step(4'b0011);
      n_after_rst += 3;
      check("postrst_l3", l3_o, 1);
      check("postrst_pair", l3_pair_o, 3'b001);
      wait_valid(200, waited);
      check("postrst_valid", scaler_valid_o, 1);
      check("postrst_first_valid", n_after_rst + waited, GATE_CYCLES);
      trig_i = 4'b0000;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
